// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: main control FSM of the multicycle MIPS core.
// One microstep per clock; drives datapath enables and mux selects.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   op[5:0]      opcode from IR[31:26]
//   zero         ALU zero flag (feeds pc_en in BEQ)
//   pc_en ir_wr mem_wr reg_wr   register/memory strobes
//   iord reg_dst mem_to_reg alu_src_a alu_src_b alu_op pc_src  selects
//   illegal      one-cycle pulse in DECODE on an unknown opcode
//   state[3:0]   current state for debug
//
// Build option: define MULTI_CTRL_ADDI_EN to add the addi path
// (IMMEX/IMMWB). Without it, addi decodes as illegal.

module multi_cycle_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic       zero,
  output logic       pc_en,
  output logic       ir_wr,
  output logic       mem_wr,
  output logic       iord,
  output logic       reg_wr,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BEQ    = 4'd8;
`ifdef MULTI_CTRL_ADDI_EN
  localparam logic [3:0] S_IMMEX  = 4'd9;
  localparam logic [3:0] S_IMMWB  = 4'd10;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  logic [3:0] nxt;
  logic       dec_ill;
  logic       pc_write;
  logic       branch;
  logic       ir_raw;
  logic       mem_wr_raw;
  logic       reg_wr_raw;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = S_FETCH;
    dec_ill = 1'b0;
    case (state)
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LW),
          (op == OP_SW):  nxt = S_MEMADR;
          (op == OP_R):   nxt = S_EXEC;
          (op == OP_BEQ): nxt = S_BEQ;
          (op == OP_J):   nxt = S_JUMP;
`ifdef MULTI_CTRL_ADDI_EN
          (op == OP_ADDI): nxt = S_IMMEX;
`endif
          default: dec_ill = 1'b1;
        endcase
      end
      S_MEMADR: nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  nxt = S_MEMWB;
      S_EXEC:   nxt = S_ALUWB;
`ifdef MULTI_CTRL_ADDI_EN
      S_IMMEX:  nxt = S_IMMWB;
`endif
      default:  nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    branch     = 1'b0;
    ir_raw     = 1'b0;
    mem_wr_raw = 1'b0;
    reg_wr_raw = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_src     = 2'b00;
    case (state)
      S_FETCH: begin
        ir_raw    = 1'b1;
        pc_write  = 1'b1;
        alu_src_b = 2'b01;
      end
      S_DECODE: alu_src_b = 2'b11;
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: iord = 1'b1;
      S_MEMWB: begin
        reg_wr_raw = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord       = 1'b1;
        mem_wr_raw = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_ALUWB: begin
        reg_wr_raw = 1'b1;
        reg_dst    = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        branch    = 1'b1;
      end
`ifdef MULTI_CTRL_ADDI_EN
      S_IMMEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_IMMWB: reg_wr_raw = 1'b1;
`endif
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by rst so nothing writes while reset is held,
  // including the cycle in which reset aborts an instruction.
  assign pc_en   = (pc_write | (branch & zero)) & ~rst;
  assign ir_wr   = ir_raw & ~rst;
  assign mem_wr  = mem_wr_raw & ~rst;
  assign reg_wr  = reg_wr_raw & ~rst;
  assign illegal = dec_ill & ~rst;

endmodule
